hazard_ctrl: RTL and testbench

// Pipeline hazard controller for the 3-stage RV32I core. Generates stall/bubble/flush controls for
// the PC, the fetch/decode register and the decode-read stage (its stall and bubble inputs), and
// the execute stage. Resolves three event types:
// - load-use interlocks
// - taken-branch/jump redirects
// - multi-cycle memory waits

---
 rtl/hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_ctrl_load_use_detect.sv | 29 ++
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   HZ_RUN / HZ_FLUSH / HZ_MEMW : FSM state encodings (2-bit)
//   FCNT_W                      : width of the flush-cycle counter (FLUSH_CYCLES up to 7)
//   REG_ADDR_W                  : register-file address width (RV32I)
//   hz_ctrl_t                   : bundle of pipeline control outputs
package hazard_ctrl_pkg;

    localparam int unsigned HZ_STATE_W = 2;
    localparam int unsigned FCNT_W     = 3;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [HZ_STATE_W-1:0] HZ_RUN   = 2'd0;
    localparam logic [HZ_STATE_W-1:0] HZ_FLUSH = 2'd1;
    localparam logic [HZ_STATE_W-1:0] HZ_MEMW  = 2'd2;

    typedef struct packed {
        logic pc_stall;
        logic fd_stall;
        logic fd_flush;
        logic dec_stall;
        logic dec_bubble;
        logic ex_stall;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: flags when the instruction in decode reads
// a register that the load currently in execute has not yet produced.
//   dec_rs1_i/dec_rs2_i, dec_uses_rs1_i/dec_uses_rs2_i : decode source operands
//   ex_rd_i, ex_reg_we_i, ex_mem_rr_i                  : execute destination / load flag
//   lu_o                                               : interlock required
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] dec_rs1_i,
    input  logic [REG_ADDR_W-1:0] dec_rs2_i,
    input  logic                  dec_uses_rs1_i,
    input  logic                  dec_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_reg_we_i,
    input  logic                  ex_mem_rr_i,
    output logic                  lu_o
);

    logic rd_live;
    logic hit_rs1;
    logic hit_rs2;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign rd_live = ex_mem_rr_i & ex_reg_we_i & (ex_rd_i != REG_ADDR_W'(0));
    assign hit_rs1 = dec_uses_rs1_i & (dec_rs1_i == ex_rd_i);
    assign hit_rs2 = dec_uses_rs2_i & (dec_rs2_i == ex_rd_i);
    assign lu_o    = rd_live & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 3-stage RV32I core.
// Produces PC / fetch-decode / decode-read / execute stall, bubble and flush
// controls from load-use interlocks, taken-branch redirects and memory waits,
// and keeps stall/flush performance counters.
//   clk, rst          : clock, synchronous active-high reset
//   dec_*_i           : decode operand info
//   ex_*_i            : execute destination, load flag, redirect
//   mem_busy_i        : imem/dmem cannot complete this cycle
//   *_stall_o etc.    : combinational pipeline controls
//   stall_cnt_o       : cycles with pc_stall since reset
//   flush_cnt_o       : accepted redirects since reset
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] dec_rs1_i,
    input  logic [REG_ADDR_W-1:0] dec_rs2_i,
    input  logic                  dec_uses_rs1_i,
    input  logic                  dec_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_reg_we_i,
    input  logic                  ex_mem_rr_i,
    input  logic                  ex_redirect_i,
    input  logic                  mem_busy_i,
    output logic                  pc_stall_o,
    output logic                  fd_stall_o,
    output logic                  fd_flush_o,
    output logic                  dec_stall_o,
    output logic                  dec_bubble_o,
    output logic                  ex_stall_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    logic [HZ_STATE_W-1:0] state_q, state_d;
    logic [HZ_STATE_W-1:0] eval_state;
    logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
    logic [CNT_W-1:0]      stall_cnt_q, flush_cnt_q;
    logic                  lu;
    logic                  redirect_acc;
    hz_ctrl_t              ctrl;

    load_use_detect u_lu (
        .dec_rs1_i      (dec_rs1_i),
        .dec_rs2_i      (dec_rs2_i),
        .dec_uses_rs1_i (dec_uses_rs1_i),
        .dec_uses_rs2_i (dec_uses_rs2_i),
        .ex_rd_i        (ex_rd_i),
        .ex_reg_we_i    (ex_reg_we_i),
        .ex_mem_rr_i    (ex_mem_rr_i),
        .lu_o           (lu)
    );

    // Leaving MEM_WAIT, this cycle behaves as the state the wait interrupted
    always_comb begin
        eval_state = state_q;
        if (state_q == HZ_MEMW && !mem_busy_i) begin
            eval_state = (fcnt_q != FCNT_W'(0)) ? HZ_FLUSH : HZ_RUN;
        end
    end

    // Next-state and Mealy control outputs
    always_comb begin
        ctrl         = '0;
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        redirect_acc = 1'b0;

        if (rst) begin
            ctrl.fd_flush   = 1'b1;
            ctrl.dec_bubble = 1'b1;
            state_d         = HZ_RUN;
            fcnt_d          = '0;
        end else if (mem_busy_i) begin
            // Whole pipe frozen; execute re-presents any redirect once memory is free
            ctrl.pc_stall  = 1'b1;
            ctrl.fd_stall  = 1'b1;
            ctrl.dec_stall = 1'b1;
            ctrl.ex_stall  = 1'b1;
            state_d        = HZ_MEMW;
        end else if (ex_redirect_i) begin
            ctrl.fd_flush   = 1'b1;
            ctrl.dec_bubble = 1'b1;
            redirect_acc    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
                state_d = HZ_FLUSH;
            end else begin
                fcnt_d  = '0;
                state_d = HZ_RUN;
            end
        end else begin
            case (eval_state)
                HZ_FLUSH: begin
                    ctrl.fd_flush   = 1'b1;
                    ctrl.dec_bubble = 1'b1;
                    if (fcnt_q <= FCNT_W'(1)) begin
                        fcnt_d  = '0;
                        state_d = HZ_RUN;
                    end else begin
                        fcnt_d  = fcnt_q - FCNT_W'(1);
                        state_d = HZ_FLUSH;
                    end
                end
                default: begin
                    // Single-cycle interlock: the bubble clears the load out of execute
                    if (lu) begin
                        ctrl.pc_stall   = 1'b1;
                        ctrl.fd_stall   = 1'b1;
                        ctrl.dec_bubble = 1'b1;
                    end
                    state_d = HZ_RUN;
                end
            endcase
        end
    end

    // State, flush counter and performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HZ_RUN;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (ctrl.pc_stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect_acc) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign pc_stall_o   = ctrl.pc_stall;
    assign fd_stall_o   = ctrl.fd_stall;
    assign fd_flush_o   = ctrl.fd_flush;
    assign dec_stall_o  = ctrl.dec_stall;
    assign dec_bubble_o = ctrl.dec_bubble;
    assign ex_stall_o   = ctrl.ex_stall;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (FLUSH_CYCLES=2, CNT_W=4).
// Control bits in expectations are ordered {pc_stall, fd_stall, fd_flush, dec_stall, dec_bubble, ex_stall}.
module tb_hazard_ctrl;

    localparam int unsigned CW = 4;

    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_LU    = 6'b110010;
    localparam logic [5:0] C_FLUSH = 6'b001010;
    localparam logic [5:0] C_BUSY  = 6'b110101;

    typedef struct packed {
        logic [5:0]    ctrl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    dec_rs1, dec_rs2, ex_rd;
    logic          dec_uses_rs1, dec_uses_rs2, ex_reg_we, ex_mem_rr, ex_redirect, mem_busy;
    logic          pc_stall, fd_stall, fd_flush, dec_stall, dec_bubble, ex_stall;
    logic [CW-1:0] stall_cnt, flush_cnt;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .dec_rs1_i      (dec_rs1),
        .dec_rs2_i      (dec_rs2),
        .dec_uses_rs1_i (dec_uses_rs1),
        .dec_uses_rs2_i (dec_uses_rs2),
        .ex_rd_i        (ex_rd),
        .ex_reg_we_i    (ex_reg_we),
        .ex_mem_rr_i    (ex_mem_rr),
        .ex_redirect_i  (ex_redirect),
        .mem_busy_i     (mem_busy),
        .pc_stall_o     (pc_stall),
        .fd_stall_o     (fd_stall),
        .fd_flush_o     (fd_flush),
        .dec_stall_o    (dec_stall),
        .dec_bubble_o   (dec_bubble),
        .ex_stall_o     (ex_stall),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [5:0] act;
            e   = exp_q.pop_front();
            act = {pc_stall, fd_stall, fd_flush, dec_stall, dec_bubble, ex_stall};
            checks++;
            if (act !== e.ctrl || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                errors++;
                $display("FAIL check#%0d t=%0t: ctrl=%b sc=%0d fc=%0d, expected ctrl=%b sc=%0d fc=%0d",
                         checks, $time, act, stall_cnt, flush_cnt, e.ctrl, e.sc, e.fc);
            end
        end
    end

    // One clock of stimulus with its expected response
    task automatic step(input logic r, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic rr,
                        input logic redir, input logic busy,
                        input logic [5:0] ectrl, input int esc, input int efc);
        exp_t e;
        rst = r; dec_rs1 = rs1; dec_uses_rs1 = u1; dec_rs2 = rs2; dec_uses_rs2 = u2;
        ex_rd = rd; ex_reg_we = we; ex_mem_rr = rr; ex_redirect = redir; mem_busy = busy;
        e.ctrl = ectrl; e.sc = CW'(esc); e.fc = CW'(efc);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r, input logic redir, input logic busy,
                        input logic [5:0] ectrl, input int esc, input int efc);
        step(r, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, redir, busy, ectrl, esc, efc);
    endtask

    // Load in execute writing x5, decode reading x5 via rs1
    task automatic lu_step(input logic redir, input logic [5:0] ectrl, input int esc, input int efc);
        step(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, redir, 1'b0, ectrl, esc, efc);
    endtask

    initial begin
        rst = 1'b1; dec_rs1 = '0; dec_rs2 = '0; dec_uses_rs1 = 1'b0; dec_uses_rs2 = 1'b0;
        ex_rd = '0; ex_reg_we = 1'b0; ex_mem_rr = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        idle(1'b1, 1'b0, 1'b0, C_FLUSH, 0, 0);

        // Load-use: one stall cycle, then clear
        lu_step(1'b0, C_LU, 0, 0);
        idle(1'b0, 1'b0, 1'b0, C_IDLE, 1, 0);

        // x0 destination and unused operands never interlock
        step(1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_IDLE, 1, 0);
        step(1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_IDLE, 1, 0);
        // Not a load / not writing: no interlock
        step(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_IDLE, 1, 0);
        step(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, C_IDLE, 1, 0);
        // rs2 match interlocks
        step(1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, C_LU, 1, 0);
        idle(1'b0, 1'b0, 1'b0, C_IDLE, 2, 0);

        // Redirect + load-use together: two flush cycles, lu ignored in FLUSH
        lu_step(1'b1, C_FLUSH, 2, 0);
        lu_step(1'b0, C_FLUSH, 2, 1);
        idle(1'b0, 1'b0, 1'b0, C_IDLE, 2, 1);

        // mem_busy for 3 cycles during FLUSH (counter=1), redirect ignored while busy
        idle(1'b0, 1'b1, 1'b0, C_FLUSH, 2, 1);
        idle(1'b0, 1'b0, 1'b1, C_BUSY, 2, 2);
        idle(1'b0, 1'b1, 1'b1, C_BUSY, 3, 2);
        idle(1'b0, 1'b0, 1'b1, C_BUSY, 4, 2);
        idle(1'b0, 1'b0, 1'b0, C_FLUSH, 5, 2);
        idle(1'b0, 1'b0, 1'b0, C_IDLE, 5, 2);

        // mem_busy from RUN returns straight to RUN
        idle(1'b0, 1'b0, 1'b1, C_BUSY, 5, 2);
        idle(1'b0, 1'b0, 1'b0, C_IDLE, 6, 2);

        // Reset while in MEM_WAIT with a flush pending
        idle(1'b0, 1'b1, 1'b0, C_FLUSH, 6, 2);
        idle(1'b0, 1'b0, 1'b1, C_BUSY, 6, 3);
        idle(1'b1, 1'b0, 1'b1, C_FLUSH, 7, 3);
        idle(1'b1, 1'b0, 1'b0, C_FLUSH, 0, 0);
        idle(1'b0, 1'b0, 1'b0, C_IDLE, 0, 0);

        // Redirect inside FLUSH reloads the counter
        idle(1'b0, 1'b1, 1'b0, C_FLUSH, 0, 0);
        idle(1'b0, 1'b1, 1'b0, C_FLUSH, 0, 1);
        idle(1'b0, 1'b0, 1'b0, C_FLUSH, 0, 2);
        idle(1'b0, 1'b0, 1'b0, C_IDLE, 0, 2);

        // 17 load-use stalls on a 4-bit counter wrap to 1
        idle(1'b1, 1'b0, 1'b0, C_FLUSH, 0, 2);
        for (int k = 0; k < 17; k++) begin
            lu_step(1'b0, C_LU, k % 16, 0);
            idle(1'b0, 1'b0, 1'b0, C_IDLE, (k + 1) % 16, 0);
        end

        // Drain the scoreboard with a bounded wait
        for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
